mfp_ahb_bot_master: RTL and testbench
=====================================

# mfp_ahb_bot_master

AHB-Lite initiator that services the Rojobot IO block in hardware, with no MIPS software in the loop. It polls the bot's update-sync register over the bus. On each update it:
- reads the bot info word,
- writes a control byte supplied by local logic,
- pulses the interrupt-acknowledge register (write 1, then write 0).

It sits on a secondary AHB-Lite master port in front of the Rojobot IO responder (HSEL decoded externally).

## Interface
Parameters:
- BASE_ADDR, 32'h1F80_0000, base of the Rojobot IO region; register offsets are added to it.
- POLL_GAP, 16, idle cycles between consecutive polls of UPD_SYNC (≥1).

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESET  in  1  synchronous, active-high reset.
- HREADY  in  1  transfer-done from responder.
- HRDATA  in  32  read data.
- HADDR  out  32  address.
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- HWRITE  out  1  write strobe.
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  constant 3'b000 (single).
- HWDATA  out  32  write data, driven in the data phase.
- en  in  1  enable servicing.
- ctrl_cmd  in  8  control byte written to BOT_CTRL; sampled when the info read completes.
- bot_info  out  32  last BOT_INFO word read.
- info_valid  out  1  one-cycle pulse when bot_info updates.
- busy  out  1  high in any state other than S_IDLE or S_WAIT.
- svc_count  out  16  completed service sequences; wraps at 16'hFFFF→0.

## Operation
Register offsets: UPD_SYNC 0x14 (read, bit0), BOT_INFO 0x0C (read), BOT_CTRL 0x10 (write, [7:0]), INT_ACK 0x18 (write, bit0).

Every transfer is a single, non-pipelined transfer:
- Address phase: HTRANS=NONSEQ.
- Data phase: HTRANS=IDLE.
- HWRITE=0 and HADDR=BASE_ADDR whenever HTRANS=IDLE. The responder qualifies writes on the delayed HSEL/HWRITE only, so a stray HWRITE would cause a spurious write.

FSM states: S_IDLE, S_POLL_A/D, S_INFO_A/D, S_CTRL_A/D, S_ACK1_A/D, S_ACK0_A/D, S_WAIT.
- S_IDLE: if en, go to S_POLL_A.
- Any *_A state: drive NONSEQ with the target address; advance to *_D when HREADY=1, otherwise hold all address-phase signals.
- Any *_D state: HTRANS=IDLE; write states hold HWDATA. Stay until HREADY=1, then complete the transfer:
  - POLL_D: if HRDATA[0]=1, go to S_INFO_A; else go to S_WAIT.
  - INFO_D: capture bot_info<=HRDATA; pulse info_valid; latch ctrl_cmd; go to S_CTRL_A.
  - CTRL_D: HWDATA={24'h0, latched ctrl_cmd}; then go to S_ACK1_A.
  - ACK1_D: HWDATA=32'h1; then go to S_ACK0_A.
  - ACK0_D: HWDATA=32'h0; increment svc_count; go to S_WAIT.
- S_WAIT: load counter with POLL_GAP-1 and count down. At 0, go to S_POLL_A if en, else S_IDLE.

en deasserted mid-sequence: the current sequence completes through ACK0; the block stops at the next S_WAIT exit.

Reset values: HTRANS=IDLE, HWRITE=0, HADDR=BASE_ADDR, HWDATA=0, bot_info=0, info_valid=0, busy=0, svc_count=0, FSM=S_IDLE, gap counter=0.

Reset mid-transfer (synchronous): the bus returns to IDLE on the next edge. The abandoned data phase is not retried.

## Timing
- Each transfer takes 2 cycles when HREADY=1; each HREADY-low cycle in a phase adds 1 cycle.
- Full service with HREADY=1: 10 cycles from the POLL_A edge to the svc_count increment.
- Poll with no update: 2 cycles, then POLL_GAP wait cycles.
- info_valid is asserted in the cycle after INFO_D completes, aligned with the new bot_info.
- The responder registers HRDATA at the end of the address phase, so HRDATA is valid throughout the data phase. The block samples it only on the data-phase HREADY=1 edge.

## Structure
- Add to mfp_ahb_const.vh: the offsets H_BOT_INFO_OFS, H_BOT_CTRL_OFS, H_BOT_UPD_OFS, H_BOT_ACK_OFS, and the HTRANS/HSIZE/HBURST codes. These offsets are shared with the Rojobot IO responder.
- Sub-module mfp_ahb_master_xfer: a single-transfer engine (start, addr, wdata, write → bus signals, done, rdata, with HREADY stall handling). The top-level FSM sequences it.

## Test plan
- Responder model with HREADY=1, UPD_SYNC=0: only reads to BASE+0x14 appear, spaced 2+POLL_GAP cycles; HWRITE is never 1.
- UPD_SYNC=1, BOT_INFO=32'hDEAD_BEEF, ctrl_cmd=8'h33 → bus sequence R 0x14, R 0x0C, W 0x10=0x33, W 0x18=1, W 0x18=0. Also: bot_info=DEADBEEF with one info_valid pulse, svc_count=1, 10 cycles total.
- HREADY held low 3 cycles during the CTRL data phase → HWDATA is stable at 0x33 across the stall; total is 13 cycles.
- en dropped during INFO_D → the sequence finishes through the ACK0 write, then S_IDLE with no further polls.
- HRESET asserted in ACK1_D → the next cycle shows HTRANS=IDLE, HWRITE=0, and all outputs at their reset values; the 0x18=0 write is not issued.
- Preload svc_count to 16'hFFFF (force), then one service → svc_count wraps to 0.

Source files
------------

// File: rtl/mfp_ahb_bot_master_pkg.sv
// Shared constants for the hardware Rojobot service master: Rojobot IO register
// offsets (also used by the responder), AHB-Lite codes and FSM state encoding.
package mfp_ahb_bot_master_pkg;

  localparam logic [7:0] H_BOT_INFO_OFS = 8'h0C;
  localparam logic [7:0] H_BOT_CTRL_OFS = 8'h10;
  localparam logic [7:0] H_BOT_UPD_OFS  = 8'h14;
  localparam logic [7:0] H_BOT_ACK_OFS  = 8'h18;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_POLL_A = 4'd1;
  localparam logic [3:0] S_POLL_D = 4'd2;
  localparam logic [3:0] S_INFO_A = 4'd3;
  localparam logic [3:0] S_INFO_D = 4'd4;
  localparam logic [3:0] S_CTRL_A = 4'd5;
  localparam logic [3:0] S_CTRL_D = 4'd6;
  localparam logic [3:0] S_ACK1_A = 4'd7;
  localparam logic [3:0] S_ACK1_D = 4'd8;
  localparam logic [3:0] S_ACK0_A = 4'd9;
  localparam logic [3:0] S_ACK0_D = 4'd10;
  localparam logic [3:0] S_WAIT   = 4'd11;

  function automatic logic [31:0] bot_reg_addr(input logic [31:0] base,
                                               input logic [7:0]  ofs);
    return base + {24'h0, ofs};
  endfunction

  function automatic logic is_addr_state(input logic [3:0] s);
    return (s == S_POLL_A) || (s == S_INFO_A) || (s == S_CTRL_A) ||
           (s == S_ACK1_A) || (s == S_ACK0_A);
  endfunction

endpackage

// File: rtl/mfp_ahb_master_xfer.sv
// Single non-pipelined AHB-Lite transfer engine: one address phase, one data
// phase, both stretched by HREADY. Bus is parked at IDLE/BASE_ADDR otherwise.
module mfp_ahb_master_xfer #(
  parameter logic [31:0] BASE_ADDR = 32'h1F80_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        write,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  output logic        addr_done,
  output logic        done,
  output logic [31:0] rdata
);
  import mfp_ahb_bot_master_pkg::*;

  logic        dphase;
  logic [31:0] hwdata_q;
  logic        aphase;

  assign aphase    = start && !dphase;
  assign addr_done = aphase && HREADY;
  assign done      = dphase && HREADY;
  assign rdata     = HRDATA;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dphase   <= 1'b0;
      hwdata_q <= 32'h0;
    end else if (addr_done) begin
      dphase <= 1'b1;
      if (write) hwdata_q <= wdata;
    end else if (done) begin
      dphase <= 1'b0;
    end
  end

  // The responder qualifies writes on registered HSEL/HWRITE, so HWRITE and
  // HADDR must never leak outside a real address phase.
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = BASE_ADDR;
    HWRITE = 1'b0;
    if (aphase) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = addr;
      HWRITE = write;
    end
  end

  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign HWDATA = hwdata_q;

endmodule

// File: rtl/mfp_ahb_bot_master.sv
// Hardware Rojobot service master: polls UPD_SYNC, then reads BOT_INFO, writes
// BOT_CTRL and pulses INT_ACK, all through a single-transfer AHB-Lite engine.
module mfp_ahb_bot_master #(
  parameter logic [31:0] BASE_ADDR = 32'h1F80_0000,
  parameter int unsigned POLL_GAP  = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        en,
  input  logic [7:0]  ctrl_cmd,
  output logic [31:0] bot_info,
  output logic        info_valid,
  output logic        busy,
  output logic [15:0] svc_count
);
  import mfp_ahb_bot_master_pkg::*;

  localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

  logic [3:0]  state;
  logic [3:0]  state_nx;
  logic [15:0] gap_cnt;
  logic [7:0]  ctrl_q;

  logic        x_start;
  logic        x_write;
  logic [7:0]  x_ofs;
  logic [31:0] x_wdata;
  logic        x_addr_done;
  logic        x_done;
  logic [31:0] x_rdata;

  // Both phases of a transfer present the same request; the engine only
  // consumes it during the address phase.
  always_comb begin
    x_ofs   = H_BOT_UPD_OFS;
    x_write = 1'b0;
    x_wdata = 32'h0;
    case (state)
      S_INFO_A, S_INFO_D: x_ofs = H_BOT_INFO_OFS;
      S_CTRL_A, S_CTRL_D: begin
        x_ofs   = H_BOT_CTRL_OFS;
        x_write = 1'b1;
        x_wdata = {24'h0, ctrl_q};
      end
      S_ACK1_A, S_ACK1_D: begin
        x_ofs   = H_BOT_ACK_OFS;
        x_write = 1'b1;
        x_wdata = 32'h1;
      end
      S_ACK0_A, S_ACK0_D: begin
        x_ofs   = H_BOT_ACK_OFS;
        x_write = 1'b1;
        x_wdata = 32'h0;
      end
      default: ;
    endcase
    x_start = is_addr_state(state);
  end

  mfp_ahb_master_xfer #(
    .BASE_ADDR (BASE_ADDR)
  ) u_xfer (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (x_start),
    .addr      (bot_reg_addr(BASE_ADDR, x_ofs)),
    .wdata     (x_wdata),
    .write     (x_write),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .addr_done (x_addr_done),
    .done      (x_done),
    .rdata     (x_rdata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (en) state_nx = S_POLL_A;
      S_POLL_A: if (x_addr_done) state_nx = S_POLL_D;
      S_POLL_D: if (x_done) state_nx = x_rdata[0] ? S_INFO_A : S_WAIT;
      S_INFO_A: if (x_addr_done) state_nx = S_INFO_D;
      S_INFO_D: if (x_done) state_nx = S_CTRL_A;
      S_CTRL_A: if (x_addr_done) state_nx = S_CTRL_D;
      S_CTRL_D: if (x_done) state_nx = S_ACK1_A;
      S_ACK1_A: if (x_addr_done) state_nx = S_ACK1_D;
      S_ACK1_D: if (x_done) state_nx = S_ACK0_A;
      S_ACK0_A: if (x_addr_done) state_nx = S_ACK0_D;
      S_ACK0_D: if (x_done) state_nx = S_WAIT;
      // en is only consulted here, so a dropped en lets the sequence finish.
      S_WAIT:   if (gap_cnt == 16'h0) state_nx = en ? S_POLL_A : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= S_IDLE;
      gap_cnt    <= 16'h0;
      bot_info   <= 32'h0;
      info_valid <= 1'b0;
      svc_count  <= 16'h0;
    end else begin
      state      <= state_nx;
      info_valid <= 1'b0;
      if (state == S_INFO_D && x_done) begin
        bot_info   <= x_rdata;
        info_valid <= 1'b1;
      end
      if (state == S_ACK0_D && x_done) svc_count <= svc_count + 16'd1;
      if (state_nx == S_WAIT && state != S_WAIT) gap_cnt <= GAP_LOAD;
      else if (state == S_WAIT && gap_cnt != 16'h0) gap_cnt <= gap_cnt - 16'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (state == S_INFO_D && x_done) ctrl_q <= ctrl_cmd;
  end

  assign busy = (state != S_IDLE) && (state != S_WAIT);

endmodule

// File: tb/tb_mfp_ahb_bot_master.sv
// Directed bench for mfp_ahb_bot_master with a Rojobot IO responder model and a
// scoreboard of expected bus transfers.
module tb_mfp_ahb_bot_master;

  localparam logic [31:0] BASE   = 32'h1F80_0000;
  localparam int          GAP    = 5;
  localparam logic [31:0] A_INFO = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL = BASE + 32'h10;
  localparam logic [31:0] A_UPD  = BASE + 32'h14;
  localparam logic [31:0] A_ACK  = BASE + 32'h18;

  logic        HCLK     = 1'b0;
  logic        HRESET   = 1'b1;
  logic        HREADY   = 1'b1;
  logic [31:0] HRDATA   = 32'h0;
  logic        en       = 1'b0;
  logic [7:0]  ctrl_cmd = 8'h0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] bot_info;
  logic        info_valid;
  logic        busy;
  logic [15:0] svc_count;

  mfp_ahb_bot_master #(
    .BASE_ADDR (BASE),
    .POLL_GAP  (GAP)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HREADY     (HREADY),
    .HRDATA     (HRDATA),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HWDATA     (HWDATA),
    .en         (en),
    .ctrl_cmd   (ctrl_cmd),
    .bot_info   (bot_info),
    .info_valid (info_valid),
    .busy       (busy),
    .svc_count  (svc_count)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  int          poll_cyc[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nxfer = 0;
  int          iv_count = 0;
  int          stall_cfg = 0;
  int          stall_left = 0;
  logic        upd_sync = 1'b0;
  logic [31:0] info_word = 32'h0;
  logic        dp_pend = 1'b0;
  logic        dp_wr = 1'b0;
  logic        dp_seen = 1'b0;
  logic [31:0] dp_addr = 32'h0;
  logic [31:0] dp_wd0 = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of responder + bus monitor, evaluated on the falling edge.
  task automatic tick();
    xfer_t       e;
    logic [31:0] d;
    @(negedge HCLK);
    cyc++;
    if (dp_pend && dp_wr && dp_addr == A_CTRL && stall_left > 0) begin
      HREADY = 1'b0;
      stall_left--;
    end else begin
      HREADY = 1'b1;
    end
    if (HTRANS == 2'b00) begin
      chk("idle_hwrite", {31'h0, HWRITE}, 32'h0);
      chk("idle_haddr", HADDR, BASE);
    end else begin
      chk("htrans_code", {30'h0, HTRANS}, 32'h2);
      chk("hsize_hburst", {26'h0, HSIZE, HBURST}, {26'h0, 3'b010, 3'b000});
    end
    if (dp_pend) begin
      if (dp_wr && dp_seen) chk("hwdata_hold", HWDATA, dp_wd0);
      if (!dp_seen) begin
        dp_wd0  = HWDATA;
        dp_seen = 1'b1;
      end
      if (HREADY) begin
        d = dp_wr ? HWDATA : HRDATA;
        nxfer++;
        chk("xfer_expected", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("xfer_dir", {31'h0, dp_wr}, {31'h0, e.wr});
          chk("xfer_addr", dp_addr, e.addr);
          chk("xfer_data", d, e.data);
        end
        if (dp_wr && dp_addr == A_ACK && d == 32'h1) upd_sync = 1'b0;
        dp_pend = 1'b0;
      end
    end else if (HTRANS == 2'b10 && HREADY) begin
      dp_pend = 1'b1;
      dp_wr   = HWRITE;
      dp_addr = HADDR;
      dp_seen = 1'b0;
      if (HADDR == A_CTRL && HWRITE) stall_left = stall_cfg;
      if (HADDR == A_UPD) poll_cyc.push_back(cyc);
      HRDATA = (HADDR == A_UPD) ? {31'h0, upd_sync} :
               (HADDR == A_INFO) ? info_word : 32'hBAD0_F00D;
    end
    if (info_valid) begin
      iv_count++;
      chk("info_aligned", bot_info, info_word);
    end
  endtask

  task automatic push_service(input logic [31:0] info, input logic [7:0] cmd, input logic with_ack0);
    exp_q.push_back(xfer_t'{1'b0, A_UPD, 32'h1});
    exp_q.push_back(xfer_t'{1'b0, A_INFO, info});
    exp_q.push_back(xfer_t'{1'b1, A_CTRL, {24'h0, cmd}});
    exp_q.push_back(xfer_t'{1'b1, A_ACK, 32'h1});
    if (with_ack0) exp_q.push_back(xfer_t'{1'b1, A_ACK, 32'h0});
  endtask

  task automatic wait_svc(input logic [15:0] target, input int budget);
    int n = 0;
    while (svc_count !== target && n < budget) begin
      tick();
      n++;
    end
    chk("svc_wait", {16'h0, svc_count}, {16'h0, target});
  endtask

  initial begin
    int   t0;
    int   t_end;
    int   n;
    logic found;

    repeat (3) tick();
    chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("rst_haddr", HADDR, BASE);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_bot_info", bot_info, 32'h0);
    chk("rst_info_valid", {31'h0, info_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_svc", {16'h0, svc_count}, 32'h0);
    HRESET = 1'b0;

    // Polls only: UPD_SYNC stays 0.
    for (int i = 0; i < 4; i++) exp_q.push_back(xfer_t'{1'b0, A_UPD, 32'h0});
    t0 = nxfer;
    en = 1'b1;
    n  = 0;
    while (nxfer < t0 + 4 && n < 200) begin
      tick();
      n++;
    end
    en = 1'b0;
    repeat (GAP + 6) tick();
    chk("poll_count", nxfer - t0, 4);
    for (int i = 1; i < 4; i++) chk("poll_spacing", poll_cyc[i] - poll_cyc[i-1], 2 + GAP);
    chk("poll_svc", {16'h0, svc_count}, 32'h0);

    // One full service.
    poll_cyc.delete();
    iv_count  = 0;
    upd_sync  = 1'b1;
    info_word = 32'hDEAD_BEEF;
    ctrl_cmd  = 8'h33;
    push_service(32'hDEAD_BEEF, 8'h33, 1'b1);
    en = 1'b1;
    wait_svc(16'd1, 100);
    t_end = cyc;
    en = 1'b0;
    chk("svc_cycles", t_end - poll_cyc[0], 10);
    repeat (GAP + 6) tick();
    chk("svc_drained", exp_q.size(), 0);
    chk("info_pulses", iv_count, 1);
    chk("bot_info", bot_info, 32'hDEAD_BEEF);
    chk("busy_after", {31'h0, busy}, 32'h0);

    // HREADY low for 3 cycles in the BOT_CTRL data phase.
    poll_cyc.delete();
    stall_cfg = 3;
    upd_sync  = 1'b1;
    info_word = 32'h1234_5678;
    push_service(32'h1234_5678, 8'h33, 1'b1);
    en = 1'b1;
    wait_svc(16'd2, 100);
    t_end = cyc;
    en = 1'b0;
    stall_cfg = 0;
    chk("stall_cycles", t_end - poll_cyc[0], 13);
    repeat (GAP + 6) tick();
    chk("stall_drained", exp_q.size(), 0);

    // en dropped during the BOT_INFO data phase.
    upd_sync  = 1'b1;
    info_word = 32'hA5A5_0F0F;
    ctrl_cmd  = 8'h5A;
    push_service(32'hA5A5_0F0F, 8'h5A, 1'b1);
    t0 = nxfer;
    en = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      tick();
      n++;
      found = (HTRANS == 2'b00) && busy && (dp_addr == A_INFO);
    end
    en = 1'b0;
    chk("found_info_d", {31'h0, found}, 32'h1);
    wait_svc(16'd3, 100);
    repeat (4 * GAP) tick();
    chk("endrop_drained", exp_q.size(), 0);
    chk("endrop_xfers", nxfer - t0, 5);
    chk("endrop_busy", {31'h0, busy}, 32'h0);

    // Synchronous reset in the ACK1 data phase.
    upd_sync  = 1'b1;
    info_word = 32'h0BAD_CAFE;
    ctrl_cmd  = 8'h77;
    push_service(32'h0BAD_CAFE, 8'h77, 1'b0);
    en = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      tick();
      n++;
      found = (HTRANS == 2'b00) && busy && (HWDATA == 32'h1);
    end
    chk("found_ack1_d", {31'h0, found}, 32'h1);
    HRESET = 1'b1;
    en     = 1'b0;
    tick();
    chk("mrst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("mrst_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("mrst_haddr", HADDR, BASE);
    chk("mrst_hwdata", HWDATA, 32'h0);
    chk("mrst_bot_info", bot_info, 32'h0);
    chk("mrst_info_valid", {31'h0, info_valid}, 32'h0);
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    chk("mrst_svc", {16'h0, svc_count}, 32'h0);
    HRESET = 1'b0;
    repeat (3 * GAP) tick();
    chk("mrst_no_ack0", exp_q.size(), 0);

    // svc_count wrap from 16'hFFFF.
    force dut.svc_count = 16'hFFFF;
    tick();
    release dut.svc_count;
    chk("wrap_preload", {16'h0, svc_count}, 32'h0000_FFFF);
    upd_sync  = 1'b1;
    info_word = 32'h600D_F00D;
    ctrl_cmd  = 8'h01;
    push_service(32'h600D_F00D, 8'h01, 1'b1);
    en = 1'b1;
    wait_svc(16'h0000, 100);
    en = 1'b0;
    repeat (GAP + 6) tick();
    chk("wrap_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
